// File: rtl/systolic_sched.sv
// rtl/systolic_sched.sv - operand read sequencer and skewed result-final pulse generator
// for an N x N systolic array walking all (M/N)^2 output tiles of an M x M product.
module systolic_sched #(
    parameter int N      = 3,
    parameter int M      = 6,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = $clog2(M * M / N),
    localparam int TW    = (M / N > 1) ? $clog2(M / N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en_A,
    output logic [ADDR_W-1:0] rd_addr_A,
    output logic              rd_en_B,
    output logic [ADDR_W-1:0] rd_addr_B,
    output logic [N*N-1:0]    init_pe,
    output logic [TW-1:0]     tile_row,
    output logic [TW-1:0]     tile_col,
    output logic              busy,
    output logic              done
);

    localparam int KW = (M > 1) ? $clog2(M) : 1;
    // Skew line spans read latency, one PE hop, and the worst-case x+y diagonal.
    localparam int L  = RD_LAT + 2 * N - 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [KW-1:0] K_LAST = KW'(M - 1);
    localparam logic [TW-1:0] T_LAST = TW'(M / N - 1);

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [TW-1:0] i_q, i_d;
    logic [TW-1:0] j_q, j_d;
    logic [L-1:0]  skew_q, skew_d;
    logic [L-1:0]  fin_q, fin_d;
    logic [L:0]    skew_ext, fin_ext;
    logic          last_beat, final_beat, drained;

    always_comb begin
        last_beat  = (state_q == S_STREAM) && (k_q == K_LAST);
        final_beat = last_beat && (i_q == T_LAST) && (j_q == T_LAST);
        // A separate marker line tags only the last tile, so done never
        // reacts to a trailing pulse of an earlier tile.
        drained    = (state_q == S_DRAIN) && fin_q[L-1];

        state_d  = state_q;
        k_d      = k_q;
        i_d      = i_q;
        j_d      = j_q;
        skew_ext = {skew_q, last_beat};
        fin_ext  = {fin_q, final_beat};
        skew_d   = skew_ext[L-1:0];
        fin_d    = fin_ext[L-1:0];

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_STREAM;
                    k_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            S_STREAM: begin
                if (final_beat) begin
                    state_d = S_DRAIN;
                end else if (last_beat) begin
                    k_d = '0;
                    if (j_q == T_LAST) begin
                        j_d = '0;
                        i_d = i_q + TW'(1);
                    end else begin
                        j_d = j_q + TW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            skew_d  = '0;
            fin_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            skew_q  <= '0;
            fin_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            skew_q  <= skew_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        init_pe = '0;
        for (int x = 0; x < N; x++) begin
            for (int y = 0; y < N; y++) begin
                init_pe[x*N+y] = skew_q[RD_LAT+x+y];
            end
        end
    end

    assign rd_en_A   = (state_q == S_STREAM);
    assign rd_en_B   = (state_q == S_STREAM);
    assign rd_addr_A = ADDR_W'(i_q) * ADDR_W'(M) + ADDR_W'(k_q);
    assign rd_addr_B = ADDR_W'(j_q) * ADDR_W'(M) + ADDR_W'(k_q);
    assign tile_row  = i_q;
    assign tile_col  = j_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = drained;

endmodule

// File: tb/tb_systolic_sched.sv
// tb/tb_systolic_sched.sv - directed table-driven bench for systolic_sched (N=3, M=6, RD_LAT=1).
module tb_systolic_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       rd_en_A;
    logic [3:0] rd_addr_A;
    logic       rd_en_B;
    logic [3:0] rd_addr_B;
    logic [8:0] init_pe;
    logic       tile_row;
    logic       tile_col;
    logic       busy;
    logic       done;

    systolic_sched #(.N(3), .M(6), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .rd_en_A   (rd_en_A),
        .rd_addr_A (rd_addr_A),
        .rd_en_B   (rd_en_B),
        .rd_addr_B (rd_addr_B),
        .init_pe   (init_pe),
        .tile_row  (tile_row),
        .tile_col  (tile_col),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic       rd;
        logic [3:0] a;
        logic [3:0] b;
        logic [8:0] ip;
        logic       tr;
        logic       tc;
        logic       bz;
        logic       dn;
    } vec_t;

    vec_t vt [16];

    int total = 0;
    int bad   = 0;

    logic       rd_h   [0:127];
    logic       done_h [0:127];
    logic       busy_h [0:127];
    logic [8:0] init_h [0:127];

    function automatic logic [22:0] outs();
        return {rd_en_A, rd_en_B, rd_addr_A, rd_addr_B, init_pe, tile_row, tile_col, busy, done};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic run(input int ncyc, input int s0, input int s1, input int s2, input int s3,
                       input int ab_c, input int rs_c, input int rs_rel, input bit use_tab);
        for (int c = 0; c < ncyc; c++) begin
            start = (c == s0) || (c == s1) || (c == s2) || (c == s3);
            abort = (c == ab_c);
            if (c == rs_rel) rst = 1'b1;
            if (c == rs_c) begin
                rst = 1'b0;
                #1;
                chk("async_rst_immediate", 32'(outs()), 32'd0);
            end
            @(negedge clk);
            rd_h[c]   = rd_en_A | rd_en_B;
            done_h[c] = done;
            busy_h[c] = busy;
            init_h[c] = init_pe;
            if (use_tab) begin
                for (int v = 0; v < 16; v++) begin
                    if (vt[v].c == c)
                        chk($sformatf("vec_c%0d", c), 32'(outs()),
                            32'({vt[v].rd, vt[v].rd, vt[v].a, vt[v].b, vt[v].ip,
                                 vt[v].tr, vt[v].tc, vt[v].bz, vt[v].dn}));
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    function automatic int count_done(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (done_h[c]) n++;
        return n;
    endfunction

    function automatic int count_rd(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (rd_h[c]) n++;
        return n;
    endfunction

    function automatic logic [8:0] or_init(input int a, input int b);
        logic [8:0] r = '0;
        for (int c = a; c <= b; c++) r = r | init_h[c];
        return r;
    endfunction

    initial begin
        vt[0]  = '{0,  1'b0, 4'd0,  4'd0,  9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1,  1'b1, 4'd0,  4'd0,  9'h000, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{6,  1'b1, 4'd5,  4'd5,  9'h000, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{7,  1'b1, 4'd0,  4'd6,  9'h000, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{8,  1'b1, 4'd1,  4'd7,  9'h001, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{9,  1'b1, 4'd2,  4'd8,  9'h00A, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{10, 1'b1, 4'd3,  4'd9,  9'h054, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{11, 1'b1, 4'd4,  4'd10, 9'h0A0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{12, 1'b1, 4'd5,  4'd11, 9'h100, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{13, 1'b1, 4'd6,  4'd0,  9'h000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[10] = '{19, 1'b1, 4'd6,  4'd6,  9'h000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[11] = '{24, 1'b1, 4'd11, 4'd11, 9'h100, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[12] = '{25, 1'b0, 4'd11, 4'd11, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[13] = '{26, 1'b0, 4'd11, 4'd11, 9'h001, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[14] = '{30, 1'b0, 4'd11, 4'd11, 9'h100, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[15] = '{31, 1'b0, 4'd11, 4'd11, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;

        // Reset held, then idle with no start.
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", 32'(outs()), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_no_start", 32'(outs()), 32'd0);
            @(posedge clk);
            #1;
        end

        // Full run against the hand-computed vector table.
        run(34, 0, -1, -1, -1, -1, -1, -1, 1'b1);
        chk("run_rd_count", 32'(count_rd(0, 33)), 32'd24);
        chk("run_done_count", 32'(count_done(0, 33)), 32'd1);
        for (int b = 0; b < 9; b++) begin
            int s, n, first, last;
            s = b / 3 + b % 3;
            n = 0;
            first = -1;
            last = -1;
            for (int c = 0; c < 34; c++) begin
                if (init_h[c][b]) begin
                    n++;
                    if (first < 0) first = c;
                    last = c;
                end
            end
            chk($sformatf("skew_count_b%0d", b), 32'(n), 32'd4);
            chk($sformatf("skew_first_b%0d", b), 32'(first), 32'(8 + s));
            chk($sformatf("skew_last_b%0d", b), 32'(last), 32'(26 + s));
        end

        // Starts while busy and coincident with done are dropped.
        run(45, 0, 5, 30, -1, -1, -1, -1, 1'b0);
        chk("ignore_start_done_count", 32'(count_done(0, 44)), 32'd1);
        chk("ignore_start_done_cyc", 32'(done_h[30]), 32'd1);
        chk("ignore_start_rd_count", 32'(count_rd(0, 44)), 32'd24);
        chk("ignore_start_busy31", 32'(busy_h[31]), 32'd0);

        // A start one cycle after done launches a second run.
        run(70, 0, 5, 30, 31, -1, -1, -1, 1'b0);
        chk("restart_rd31", 32'(rd_h[31]), 32'd0);
        chk("restart_rd32", 32'(rd_h[32]), 32'd1);
        chk("restart_done61", 32'(done_h[61]), 32'd1);
        chk("restart_done_count", 32'(count_done(0, 69)), 32'd2);
        chk("restart_rd_count", 32'(count_rd(0, 69)), 32'd48);

        // Abort during tile (0,1).
        run(40, 0, -1, -1, -1, 10, -1, -1, 1'b0);
        chk("abort_rd10", 32'(rd_h[10]), 32'd1);
        chk("abort_init10", 32'(init_h[10]), 32'h054);
        chk("abort_rd11", 32'(rd_h[11]), 32'd0);
        chk("abort_busy11", 32'(busy_h[11]), 32'd0);
        chk("abort_no_rd_after", 32'(count_rd(11, 39)), 32'd0);
        chk("abort_no_init_after", 32'(or_init(11, 39)), 32'd0);
        chk("abort_no_done", 32'(count_done(0, 39)), 32'd0);

        // Asynchronous reset inside DRAIN.
        run(40, 0, -1, -1, -1, -1, 27, 29, 1'b0);
        chk("rst_drain_busy27", 32'(busy_h[27]), 32'd0);
        chk("rst_drain_no_init", 32'(or_init(27, 39)), 32'd0);
        chk("rst_drain_no_done", 32'(count_done(0, 39)), 32'd0);
        chk("rst_drain_init26", 32'(init_h[26]), 32'h001);

        // Fresh run after that reset must match the table again.
        run(34, 0, -1, -1, -1, -1, -1, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
